// File: rtl/rom_dl_router.sv
// rom_dl_router: routes ioctl download bytes to address regions, captures DIP/core-mod bytes, generates post-load core reset; ROM_DL_CHECKSUM_EN adds an index-0 byte checksum
module rom_dl_router #(
  parameter int NUM_REGIONS = 4,
  parameter int ADDR_W = 25,
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE = {25'h50000, 25'h30000, 25'h20000, 25'h0},
  parameter int DIP_BYTES = 8,
  parameter int RST_CNT_W = 16
) (
  input  logic                     clk_sys,
  input  logic                     reset_n,
  input  logic                     ioctl_download,
  input  logic [7:0]               ioctl_index,
  input  logic                     ioctl_wr,
  input  logic [ADDR_W-1:0]        ioctl_addr,
  input  logic [7:0]               ioctl_dout,
  input  logic                     soft_reset,
  input  logic [NUM_REGIONS-1:0]   port_ack,
  output logic [NUM_REGIONS-1:0]   port_req,
  output logic [NUM_REGIONS-1:0]   region_wr,
  output logic [ADDR_W-1:0]        region_addr,
  output logic [7:0]               region_data,
  output logic [8*DIP_BYTES-1:0]   dip,
  output logic [7:0]               core_mod,
  output logic                     rom_loaded,
  output logic                     core_reset,
  output logic [NUM_REGIONS-1:0]   overrun,
  output logic [15:0]              checksum
);
  logic                   wr_d, dl0_d, s_rise, s_dl, act;
  logic [7:0]             s_index, s_data;
  logic [ADDR_W-1:0]      s_addr, off;
  logic [NUM_REGIONS-1:0] hit;
  logic [RST_CNT_W-1:0]   cnt;
  logic                   dl0, dl0_rise, dl0_fall;
  assign dl0      = ioctl_download & (ioctl_index == 8'd0);
  assign dl0_rise = dl0 & ~dl0_d;
  assign dl0_fall = ~dl0 & dl0_d;
  // capture stage: detect the write rising edge and latch the byte it belongs to
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) begin
      wr_d    <= 1'b0;
      dl0_d   <= 1'b0;
      s_rise  <= 1'b0;
      s_dl    <= 1'b0;
      s_index <= '0;
      s_data  <= '0;
      s_addr  <= '0;
    end else begin
      wr_d    <= ioctl_wr;
      dl0_d   <= dl0;
      s_rise  <= ioctl_wr & ~wr_d;
      s_dl    <= ioctl_download;
      s_index <= ioctl_index;
      s_data  <= ioctl_dout;
      s_addr  <= ioctl_addr;
    end
  // bases ascend, so the last region whose base is not above the address wins
  always_comb begin
    hit = '0;
    off = '0;
    for (int i = 0; i < NUM_REGIONS; i++)
      if (s_addr >= REGION_BASE[i*ADDR_W +: ADDR_W]) begin
        hit    = '0;
        hit[i] = 1'b1;
        off    = s_addr - REGION_BASE[i*ADDR_W +: ADDR_W];
      end
    act = s_rise & s_dl & (s_index == 8'd0) & (|hit);
  end
  // region write: toggle request, one-cycle strobe, flag overrun if still unacked
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) begin
      port_req    <= '0;
      region_wr   <= '0;
      region_addr <= '0;
      region_data <= '0;
      overrun     <= '0;
    end else begin
      region_wr <= act ? hit : '0;
      overrun   <= (dl0_rise ? '0 : overrun) | (act ? hit & (port_req ^ port_ack) : '0);
      if (act) begin
        port_req    <= port_req ^ hit;
        region_addr <= off;
        region_data <= s_data;
      end
    end
  // DIP and core-mod capture from their own download indices
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) begin
      dip      <= '0;
      core_mod <= '0;
    end else if (s_rise) begin
      if (s_index == 8'd1) core_mod <= s_data;
      for (int k = 0; k < DIP_BYTES; k++)
        if (s_index == 8'd254 && s_addr == ADDR_W'(k)) dip[8*k +: 8] <= s_data;
    end
  // core reset: hold while loading or soft reset, then count down before release
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) begin
      rom_loaded <= 1'b0;
      cnt        <= '1;
      core_reset <= 1'b1;
    end else begin
      rom_loaded <= rom_loaded | dl0_fall;
      cnt        <= (soft_reset | ~rom_loaded | dl0) ? '1 : cnt - RST_CNT_W'(cnt != '0);
      core_reset <= |cnt;
    end
`ifdef ROM_DL_CHECKSUM_EN
  logic [15:0] sum;
  // checksum restarts with each index-0 download and holds once it ends
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) sum <= '0;
    else sum <= (dl0_rise ? 16'h0 : sum) + (act ? {8'h0, s_data} : 16'h0);
  assign checksum = sum;
`else
  assign checksum = 16'h0000;
`endif
endmodule

// File: tb/tb_rom_dl_router.sv
// tb_rom_dl_router: table, directed and randomized checks of rom_dl_router against a region-level model
module tb_rom_dl_router;
  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        ioctl_download = 1'b0;
  logic [7:0]  ioctl_index = '0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic        soft_reset = 1'b0;
  logic [3:0]  port_ack = '0;
  logic [3:0]  port_req, region_wr, overrun;
  logic [24:0] region_addr;
  logic [7:0]  region_data, core_mod;
  logic [63:0] dip;
  logic        rom_loaded, core_reset;
  logic [15:0] checksum;

  rom_dl_router #(.RST_CNT_W(4)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_download(ioctl_download),
    .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .soft_reset(soft_reset), .port_ack(port_ack),
    .port_req(port_req), .region_wr(region_wr), .region_addr(region_addr),
    .region_data(region_data), .dip(dip), .core_mod(core_mod),
    .rom_loaded(rom_loaded), .core_reset(core_reset), .overrun(overrun),
    .checksum(checksum));

  always #5 clk_sys = ~clk_sys;

`ifdef ROM_DL_CHECKSUM_EN
  localparam bit CK_EN = 1'b1;
`else
  localparam bit CK_EN = 1'b0;
`endif
  localparam logic [24:0] BASE [4] = '{25'h0, 25'h20000, 25'h30000, 25'h50000};

  typedef struct {
    logic [24:0] addr;
    logic [7:0]  data;
    logic [3:0]  exp_wr;
    logic [24:0] exp_addr;
  } vec_t;
  vec_t vt [5];

  int tests = 0, fails = 0;
  logic [3:0]  mreq = '0, mov = '0;
  logic [15:0] msum = '0;
  bit          auto_ack = 1'b1;
  int          pulses;
  logic [3:0]  cap_wr;
  logic [24:0] cap_addr;
  logic [7:0]  cap_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic int region_of(input logic [24:0] a);
    for (int i = 3; i >= 0; i--) if (a >= BASE[i]) return i;
    return -1;
  endfunction

  task automatic cycles(input int n);
    repeat (n) begin @(posedge clk_sys); #1; end
  endtask

  task automatic wr_byte(input logic [7:0] idx, input logic [24:0] a, input logic [7:0] d, input int hold);
    int r;
    ioctl_index = idx;
    ioctl_addr  = a;
    ioctl_dout  = d;
    ioctl_wr    = 1'b1;
    pulses      = 0;
    for (int c = 0; c < hold + 4; c++) begin
      @(posedge clk_sys); #1;
      if (c == hold - 1) ioctl_wr = 1'b0;
      if (region_wr != 0) begin
        pulses++;
        cap_wr   = region_wr;
        cap_addr = region_addr;
        cap_data = region_data;
      end
    end
    r = (idx == 8'd0 && ioctl_download) ? region_of(a) : -1;
    if (r >= 0) begin
      chk("pulse_count", pulses, 1);
      chk("region_wr", cap_wr, 32'(1 << r));
      chk("region_addr", cap_addr, a - BASE[r]);
      chk("region_data", cap_data, d);
      if (mreq[r] != port_ack[r]) mov[r] = 1'b1;
      mreq[r] = ~mreq[r];
      msum = msum + 16'(d);
      chk("port_req", port_req, mreq);
      chk("overrun", overrun, mov);
    end else
      chk("no_pulse", pulses, 0);
    if (auto_ack) port_ack = mreq;
  endtask

  task automatic dl_start;
    ioctl_index = 8'd0;
    ioctl_download = 1'b1;
    cycles(2);
    mov = '0;
    msum = '0;
  endtask

  task automatic dl_end;
    ioctl_download = 1'b0;
    cycles(3);
  endtask

  initial begin
    int n;
    logic r0;
    vt[0] = '{25'h1FFFF, 8'h11, 4'b0001, 25'h1FFFF};
    vt[1] = '{25'h20000, 8'h22, 4'b0010, 25'h0};
    vt[2] = '{25'h30000, 8'h33, 4'b0100, 25'h0};
    vt[3] = '{25'h50001, 8'h44, 4'b1000, 25'h1};
    vt[4] = '{25'h2FFFF, 8'h55, 4'b0010, 25'hFFFF};

    cycles(3);
    chk("rst_port_req", port_req, 0);
    chk("rst_region_wr", region_wr, 0);
    chk("rst_region_addr", region_addr, 0);
    chk("rst_region_data", region_data, 0);
    chk("rst_dip_lo", dip[31:0], 0);
    chk("rst_dip_hi", dip[63:32], 0);
    chk("rst_core_mod", core_mod, 0);
    chk("rst_rom_loaded", rom_loaded, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_checksum", checksum, 0);
    chk("rst_core_reset", core_reset, 1);
    reset_n = 1'b1;
    cycles(2);

    dl_start();
    for (int i = 0; i < 5; i++) begin
      wr_byte(8'd0, vt[i].addr, vt[i].data, 1);
      chk("tbl_wr", cap_wr, vt[i].exp_wr);
      chk("tbl_addr", cap_addr, vt[i].exp_addr);
    end
    wr_byte(8'd0, 25'h40000, 8'h66, 5);
    chk("wide_strobe_pulses", pulses, 1);
    chk("loading_core_reset", core_reset, 1);

    ioctl_download = 1'b0;
    n = 0;
    do begin
      @(posedge clk_sys); #1;
      n++;
      if (n == 1) chk("rom_loaded", rom_loaded, 1);
    end while (core_reset && n < 40);
    chk("release_cycles", n, 17);
    chk("load_checksum", checksum, CK_EN ? msum : 16'h0);

    soft_reset = 1'b1;
    cycles(1);
    soft_reset = 1'b0;
    cycles(1);
    chk("soft_core_reset", core_reset, 1);
    n = 0;
    do begin
      @(posedge clk_sys); #1;
      n++;
    end while (core_reset && n < 40);
    chk("soft_release_cycles", n, 15);
    chk("rom_loaded_sticky", rom_loaded, 1);

    dl_start();
    wr_byte(8'd0, 25'h0, 8'hFF, 1);
    wr_byte(8'd0, 25'h1, 8'hFF, 2);
    wr_byte(8'd0, 25'h2, 8'h03, 1);
    dl_end();
    chk("checksum_fixed", checksum, CK_EN ? 16'h0201 : 16'h0);

    dl_start();
    auto_ack = 1'b0;
    r0 = mreq[0];
    wr_byte(8'd0, 25'h100, 8'hA1, 1);
    wr_byte(8'd0, 25'h101, 8'hA2, 1);
    chk("ovr_req_back", port_req[0], r0);
    chk("ovr_flag", overrun[0], 1);
    dl_end();
    dl_start();
    chk("ovr_cleared", overrun, 0);
    port_ack = mreq;
    auto_ack = 1'b1;
    dl_end();

    ioctl_download = 1'b1;
    wr_byte(8'd254, 25'd3, 8'hA5, 1);
    chk("dip_byte3", dip[31:24], 8'hA5);
    wr_byte(8'd254, 25'd8, 8'h77, 1);
    chk("dip_hi_unchanged", dip[63:32], 0);
    chk("dip_lo_unchanged", dip[31:0], 32'hA500_0000);
    ioctl_download = 1'b0;
    wr_byte(8'd1, 25'd0, 8'h0B, 3);
    chk("core_mod", core_mod, 8'h0B);
    cycles(2);

    dl_start();
    for (int i = 0; i < 40; i++) begin
      auto_ack = ($urandom_range(0, 3) != 0);
      wr_byte(8'd0, 25'($urandom_range(0, 25'h60000)), 8'($urandom), int'($urandom_range(1, 4)));
    end
    dl_end();
    chk("rand_checksum", checksum, CK_EN ? msum : 16'h0);
    auto_ack = 1'b1;

    dl_start();
    wr_byte(8'd0, 25'h30010, 8'h5A, 1);
    ioctl_wr = 1'b1;
    cycles(1);
    reset_n = 1'b0;
    #1;
    chk("mid_port_req", port_req, 0);
    chk("mid_rom_loaded", rom_loaded, 0);
    chk("mid_core_reset", core_reset, 1);
    chk("mid_core_mod", core_mod, 0);
    chk("mid_region_addr", region_addr, 0);
    ioctl_wr = 1'b0;
    ioctl_download = 1'b0;
    mreq = '0;
    mov = '0;
    port_ack = '0;
    cycles(2);
    reset_n = 1'b1;
    cycles(30);
    chk("held_core_reset", core_reset, 1);
    chk("held_rom_loaded", rom_loaded, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
